stream_demux_1to2: RTL

STREAM_DEMUX_1TO2 -- requirements
Module: stream_demux_1to2

---
 rtl/stream_demux_1to2_pkg.sv | 14 +
 rtl/stream_demux_1to2_if.sv | 34 +++
 rtl/stream_demux_1to2_out_slot.sv | 34 +++
 rtl/stream_demux_1to2.sv | 76 +++++++
 4 files changed

// File: rtl/stream_demux_1to2_pkg.sv
// Shared definitions for the 1-to-2 packet stream demultiplexer:
// FSM state encoding and default data/counter widths.
package stream_demux_1to2_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ROUTE_A = 2'd1,
    ROUTE_B = 2'd2
  } state_t;

endpackage

// File: rtl/stream_demux_1to2_if.sv
// Bundles the input stream, both output streams and the per-output packet
// counters; the demux takes the slave view, its driver the master view.
interface stream_demux_1to2_if #(
  parameter int WIDTH = stream_demux_1to2_pkg::DEF_WIDTH,
  parameter int CNT_W = stream_demux_1to2_pkg::DEF_CNT_W
);
  logic [WIDTH-1:0] IN_DATA;
  logic             IN_VALID;
  logic             IN_LAST;
  logic             S;
  logic             IN_READY;
  logic [WIDTH-1:0] DATA_A;
  logic [WIDTH-1:0] DATA_B;
  logic             VALID_A;
  logic             VALID_B;
  logic             LAST_A;
  logic             LAST_B;
  logic             READY_A;
  logic             READY_B;
  logic [CNT_W-1:0] PKT_CNT_A;
  logic [CNT_W-1:0] PKT_CNT_B;

  modport slave (
    input  IN_DATA, IN_VALID, IN_LAST, S, READY_A, READY_B,
    output IN_READY, DATA_A, DATA_B, VALID_A, VALID_B, LAST_A, LAST_B,
           PKT_CNT_A, PKT_CNT_B
  );

  modport master (
    output IN_DATA, IN_VALID, IN_LAST, S, READY_A, READY_B,
    input  IN_READY, DATA_A, DATA_B, VALID_A, VALID_B, LAST_A, LAST_B,
           PKT_CNT_A, PKT_CNT_B
  );
endinterface

// File: rtl/stream_demux_1to2_out_slot.sv
// One-entry output register slice: loads a {last,data} word, holds it until
// the consumer takes it, and can reload in the same cycle it drains.
module out_slot #(
  parameter int W = 9
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_load,
  input  logic [W-1:0] i_data,
  input  logic         i_ready,
  output logic         o_valid,
  output logic [W-1:0] o_data,
  output logic         o_free
);
  logic         r_valid;
  logic [W-1:0] r_data;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  // Free when empty or being drained this cycle, so back-to-back loads never bubble.
  assign o_free  = !r_valid || i_ready;
endmodule

// File: rtl/stream_demux_1to2.sv
// Packet-locked 1-to-2 stream demultiplexer: the first beat's select picks
// the output, the rest of the packet follows it, and completed packets are counted.
module stream_demux_1to2
  import stream_demux_1to2_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input logic           CLK,
  input logic           RST,
  stream_demux_1to2_if.slave bus
);
  state_t         r_state;
  logic           w_target_b;
  logic           w_in_ready;
  logic           w_accept;
  logic [1:0]     w_load;
  logic [1:0]     w_free;
  logic [1:0]     w_valid;
  logic [1:0]     w_rdy;
  logic [WIDTH:0] w_din;
  logic [WIDTH:0] w_dout [2];

  // Select is only honoured on a packet's first beat.
  assign w_target_b = (r_state == IDLE) ? bus.S : (r_state == ROUTE_B);
  assign w_in_ready = !RST && (w_target_b ? w_free[1] : w_free[0]);
  assign w_accept   = bus.IN_VALID && w_in_ready;
  assign w_load     = {w_accept && w_target_b, w_accept && !w_target_b};
  assign w_rdy      = {bus.READY_B, bus.READY_A};
  assign w_din      = {bus.IN_LAST, bus.IN_DATA};

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= IDLE;
    end else if (w_accept) begin
      if (bus.IN_LAST)
        r_state <= IDLE;
      else
        r_state <= w_target_b ? ROUTE_B : ROUTE_A;
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_out
      logic [CNT_W-1:0] r_cnt;

      out_slot #(.W(WIDTH + 1)) u_slot (
        .i_clk   (CLK),
        .i_rst   (RST),
        .i_load  (w_load[gi]),
        .i_data  (w_din),
        .i_ready (w_rdy[gi]),
        .o_valid (w_valid[gi]),
        .o_data  (w_dout[gi]),
        .o_free  (w_free[gi])
      );

      always_ff @(posedge CLK or posedge RST) begin
        if (RST)
          r_cnt <= '0;
        else if (w_load[gi] && bus.IN_LAST)
          r_cnt <= r_cnt + 1'b1;
      end
    end
  endgenerate

  assign bus.IN_READY  = w_in_ready;
  assign bus.VALID_A   = w_valid[0];
  assign bus.VALID_B   = w_valid[1];
  assign bus.DATA_A    = w_dout[0][WIDTH-1:0];
  assign bus.DATA_B    = w_dout[1][WIDTH-1:0];
  assign bus.LAST_A    = w_dout[0][WIDTH];
  assign bus.LAST_B    = w_dout[1][WIDTH];
  assign bus.PKT_CNT_A = g_out[0].r_cnt;
  assign bus.PKT_CNT_B = g_out[1].r_cnt;
endmodule
